// File: rtl/mem0_stage_if.sv
// Bundle between MEM0 and its neighbours: EX input bus, MEM1 output bus,
// data-SRAM request channel and the ID bypass / dest-tag outputs.
`ifndef EX2MEM0BusSize
`define EX2MEM0BusSize 108
`endif
`ifndef MEM02MEM1BusSize
`define MEM02MEM1BusSize 78
`endif

interface mem0_stage_if;
  logic [`EX2MEM0BusSize-1:0]   ex2mem0_bus_i;
  logic                         ex_over_i;
  logic                         mem0_allowin_o;
  logic                         flush_i;
  logic                         mem1_allowin_i;
  logic                         mem0_to_mem1_valid_o;
  logic [`MEM02MEM1BusSize-1:0] mem0_to_mem1_bus_o;
  logic                         data_req_o;
  logic                         data_wr_o;
  logic [1:0]                   data_size_o;
  logic [31:0]                  data_addr_o;
  logic [3:0]                   data_wstrb_o;
  logic [31:0]                  data_wdata_o;
  logic                         data_addr_ok_i;
  logic                         data_discard_o;
  logic [31:0]                  forward_mem02id_data_o;
  logic                         forward_mem02id_valid_o;
  logic [4:0]                   ctl_mem0_dest_o;

  modport slave (
    input  ex2mem0_bus_i, ex_over_i, flush_i, mem1_allowin_i, data_addr_ok_i,
    output mem0_allowin_o, mem0_to_mem1_valid_o, mem0_to_mem1_bus_o,
           data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
           data_discard_o, forward_mem02id_data_o, forward_mem02id_valid_o, ctl_mem0_dest_o
  );

  modport master (
    output ex2mem0_bus_i, ex_over_i, flush_i, mem1_allowin_i, data_addr_ok_i,
    input  mem0_allowin_o, mem0_to_mem1_valid_o, mem0_to_mem1_bus_o,
           data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
           data_discard_o, forward_mem02id_data_o, forward_mem02id_valid_o, ctl_mem0_dest_o
  );
endinterface

// File: rtl/mem0_stage.sv
// MEM0 pipeline stage: one-slot buffer that issues the data-SRAM request.
// Define MEM0_ALIGN_CHECK_EN to trap misaligned half/word accesses (ale) instead of requesting.
`ifndef EX2MEM0BusSize
`define EX2MEM0BusSize 108
`endif
`ifndef MEM02MEM1BusSize
`define MEM02MEM1BusSize 78
`endif

module mem0_stage (
  input  logic        clk_i,
  input  logic        rstn_i,
  mem0_stage_if.slave io
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic        inst_load;
    logic        inst_store;
    logic        ld_bh_sign;
    logic [2:0]  size;        // one-hot: 4 byte, 2 half, 1 word
    logic [31:0] st_data;
    logic [31:0] exe_result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] pc;
  } ex_bus_t;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t  state_q, state_d, load_tgt;
  ex_bus_t slot_q, slot_d, in_bus;
  logic    ale_q, ale_d, discard_q, discard_d;
  logic    in_mem, in_ale, load, valid, req, is_done;
  logic [1:0] a_lo, size_code;
  logic [NUM_LANES-1:0]            lane_strb;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;

  assign in_bus = io.ex2mem0_bus_i;
  assign in_mem = in_bus.inst_load | in_bus.inst_store;

`ifdef MEM0_ALIGN_CHECK_EN
  assign in_ale = in_mem & ((in_bus.size[1] & in_bus.exe_result[0]) |
                            (in_bus.size[0] & (|in_bus.exe_result[1:0])));
`else
  assign in_ale = 1'b0;
`endif

  // A trapped access never talks to memory; it goes straight to DONE carrying ale.
  assign load_tgt = (in_mem & ~in_ale) ? S_REQ : S_DONE;

  assign valid   = (state_q != S_EMPTY);
  assign is_done = (state_q == S_DONE);
  assign req     = (state_q == S_REQ);

  assign io.mem0_allowin_o = (state_q == S_EMPTY) | (is_done & io.mem1_allowin_i);
  assign load = io.ex_over_i & io.mem0_allowin_o & ~io.flush_i;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ale_d     = ale_q;
    discard_d = 1'b0;
    if (load) begin
      slot_d = in_bus;
      ale_d  = in_ale;
    end
    case (state_q)
      S_EMPTY: if (load) state_d = load_tgt;
      S_REQ: begin
        // Once the address is accepted a response is coming; tell MEM1 to drop it.
        if (io.flush_i) begin
          state_d   = S_EMPTY;
          discard_d = io.data_addr_ok_i;
        end else if (io.data_addr_ok_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (io.flush_i) begin
          state_d   = S_EMPTY;
          discard_d = slot_q.inst_load;
        end else if (io.mem1_allowin_i) begin
          state_d = load ? load_tgt : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_EMPTY;
      slot_q    <= '0;
      ale_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ale_q     <= ale_d;
      discard_q <= discard_d;
    end
  end

  // Byte-lane strobe/data steering for stores.
  assign a_lo = slot_q.exe_result[1:0];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign lane_strb[i] = slot_q.size[2] ? (a_lo == LANE) :
                          slot_q.size[1] ? (a_lo[1] == LANE[1]) : 1'b1;
    assign lane_data[i] = slot_q.size[2] ? slot_q.st_data[VEC_W-1:0] :
                          slot_q.size[1] ? slot_q.st_data[VEC_W*(i%2) +: VEC_W] :
                                           slot_q.st_data[VEC_W*i +: VEC_W];
  end

  assign size_code = slot_q.size[2] ? 2'd0 : slot_q.size[1] ? 2'd1 : 2'd2;

  // Request fields are only driven while requesting, so they stay frozen until addr_ok.
  assign io.data_req_o   = req;
  assign io.data_wr_o    = req & slot_q.inst_store;
  assign io.data_size_o  = req ? size_code : 2'd0;
  assign io.data_addr_o  = req ? slot_q.exe_result : 32'd0;
  assign io.data_wstrb_o = (req & slot_q.inst_store) ? lane_strb : 4'd0;
  assign io.data_wdata_o = req ? lane_data : 32'd0;
  assign io.data_discard_o = discard_q;

  assign io.mem0_to_mem1_valid_o = is_done;
  assign io.mem0_to_mem1_bus_o = {slot_q.inst_load, slot_q.ld_bh_sign, slot_q.size, a_lo,
                                  slot_q.exe_result, slot_q.rd_addr, slot_q.rd_we, ale_q,
                                  slot_q.pc};

  assign io.forward_mem02id_data_o  = slot_q.exe_result & {32{valid}};
  assign io.forward_mem02id_valid_o = ~(valid & slot_q.inst_load);
  assign io.ctl_mem0_dest_o         = slot_q.rd_addr & {5{valid}};
endmodule

// File: doc/mem0_stage.md
MEM0_STAGE -- requirements
Module: mem0_stage

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rstn_i  in  1  asynchronous, active-low reset.
REQ-003 ex2mem0_bus_i  in  `EX2MEM0BusSize  {mem_ctl[5:0], st_data[31:0], exe_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}; mem_ctl = {inst_load, inst_store, ld_bh_sign, ld_st_size[2:0]}; size one-hot 4=byte, 2=half, 1=word.
REQ-004 ex_over_i  in  1  EX holds a finished, valid instruction.
REQ-005 mem0_allowin_o  out  1  stage can accept an instruction this cycle.
REQ-006 flush_i  in  1  kill the instruction held in the stage.
REQ-007 mem1_allowin_i  in  1  downstream stage can accept.
REQ-008 mem0_to_mem1_valid_o  out  1  bus to MEM1 is valid.
REQ-009 mem0_to_mem1_bus_o  out  `MEM02MEM1BusSize  {inst_load, ld_bh_sign, ld_st_size, addr_lo[1:0], exe_result, rd_addr, rd_we, ale, pc}.
REQ-010 data_req_o / data_wr_o / data_size_o[1:0] / data_addr_o[31:0] / data_wstrb_o[3:0] / data_wdata_o[31:0]  out  data-SRAM request.
REQ-011 data_addr_ok_i  in  1  request accepted this cycle.
REQ-012 data_discard_o  out  1  one-cycle pulse: MEM1 drops the next data response.
REQ-013 forward_mem02id_data_o  out  32 / forward_mem02id_valid_o  out  1  bypass to ID.
REQ-014 ctl_mem0_dest_o  out  5  rd_addr masked by stage valid.

Function
REQ-015 Stage SHALL hold one register slot (valid bit + latched bus), loaded when ex_over_i & mem0_allowin_o & ~flush_i.
REQ-016 FSM SHALL have states EMPTY, REQ (memory op, request not yet accepted), DONE (ready to go).
REQ-017 EMPTY->REQ on load of a load/store; EMPTY->DONE on load of a non-memory op; REQ->DONE on data_addr_ok_i; DONE->EMPTY when mem1_allowin_i and nothing new loaded; DONE->REQ/DONE direct on back-to-back load.
REQ-018 mem0_allowin_o SHALL equal EMPTY | (DONE & mem1_allowin_i); mem0_to_mem1_valid_o SHALL equal (state==DONE).
REQ-019 data_req_o SHALL be high only in REQ, held stable with all request fields until data_addr_ok_i; latency from load to first request = 1 cycle.
REQ-020 data_addr_o = exe_result; data_wr_o = inst_store; data_size_o = 0/1/2 for byte/half/word.
REQ-021 Store strobes: byte 4'b0001<<addr[1:0], data = st_data[7:0] replicated x4; half addr[1]?4'b1100:4'b0011, data = st_data[15:0] x2; word 4'b1111; loads drive 4'b0000.
REQ-022 flush_i in REQ without data_addr_ok_i SHALL drop req next cycle and go EMPTY, no discard pulse.
REQ-023 flush_i coincident with data_addr_ok_i (REQ), or in DONE holding a load, SHALL go EMPTY and pulse data_discard_o next cycle.
REQ-024 forward_mem02id_data_o = exe_result & {32{valid}}; forward_mem02id_valid_o = ~(valid & inst_load).
REQ-025 ctl_mem0_dest_o = rd_addr & {5{valid}}.

Reset
REQ-026 While rstn_i low: state EMPTY, slot cleared; all outputs 0 except mem0_allowin_o = 1 and forward_mem02id_valid_o = 1.
REQ-027 Reset mid-request SHALL drop data_req_o immediately (asynchronous), no discard pulse.

Configuration
REQ-028 Macro MEM0_ALIGN_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 sets ale=1, suppresses data_req_o, enters DONE directly; undefined: no check, ale tied 0, every memory op requests.

Verification
REQ-029 Word store addr 0x100, data 0xDEADBEEF, addr_ok 1 cycle later -> req 1 cycle, wstrb 1111, size 2, valid_o next cycle.
REQ-030 Byte store addr 0x103, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
REQ-031 Load, addr_ok withheld 3 cycles -> req/addr stable 3 cycles, allowin 0, forward_valid 0.
REQ-032 Flush same cycle as addr_ok on load -> state EMPTY, data_discard_o = 1 next cycle, valid_o 0.
REQ-033 Half load addr 0x101 with MEM0_ALIGN_CHECK_EN -> no req, ale=1 in bus, valid_o next cycle; without -> req, size 1.
REQ-034 ALU op while mem1_allowin_i=0 for 2 cycles -> held in DONE, allowin 0, then accepts back-to-back op in release cycle.
